// File: rtl/circuit7_seq.sv
// circuit7_seq: z = (a mod b == zero) ? c/d : a/b on one shared restoring divider.
// Define CIRCUIT7_SKIP_EN to bypass the second divide when the remainder check fails.
module circuit7_seq #(
   parameter int DATAWIDTH = 64
) (
   input  logic                 Clk,
   input  logic                 Rst,
   input  logic                 start,
   input  logic [DATAWIDTH-1:0] a,
   input  logic [DATAWIDTH-1:0] b,
   input  logic [DATAWIDTH-1:0] c,
   input  logic [DATAWIDTH-1:0] d,
   input  logic [DATAWIDTH-1:0] zero,
   output logic                 busy,
   output logic                 done,
   output logic [DATAWIDTH-1:0] z
);

   localparam int CW = $clog2(DATAWIDTH) + 1;

   typedef enum logic [2:0] {IDLE, DIV1, CHECK, DIV2, DONE} state_t;

   state_t               state_q, state_d;
   logic [DATAWIDTH-1:0] rem_q, rem_d;
   logic [DATAWIDTH-1:0] quo_q, quo_d;
   logic [DATAWIDTH-1:0] dvs_q, dvs_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [DATAWIDTH-1:0] c_q, c_d;
   logic [DATAWIDTH-1:0] d_q, d_d;
   logic [DATAWIDTH-1:0] zero_q, zero_d;
   logic [DATAWIDTH-1:0] q1_q, q1_d;
   logic                 eq_q, eq_d;
   logic [DATAWIDTH-1:0] z_q, z_d;
   logic                 done_q, done_d;

   // One restoring step; a zero divisor always subtracts, giving all-ones
   // quotient and the dividend as remainder without special casing.
   logic [DATAWIDTH:0]   shf;
   logic                 ge;
   logic [DATAWIDTH-1:0] rem_step;
   logic                 last;

   assign shf      = {rem_q, quo_q[DATAWIDTH-1]};
   assign ge       = shf >= {1'b0, dvs_q};
   assign rem_step = ge ? (shf[DATAWIDTH-1:0] - dvs_q) : shf[DATAWIDTH-1:0];
   assign last     = (cnt_q == CW'(DATAWIDTH - 1));

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) state_q <= IDLE;
      else      state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      quo_d   = quo_q;
      dvs_d   = dvs_q;
      cnt_d   = cnt_q;
      c_d     = c_q;
      d_d     = d_q;
      zero_d  = zero_q;
      q1_d    = q1_q;
      eq_d    = eq_q;
      z_d     = z_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = DIV1;
               rem_d   = '0;
               quo_d   = a;
               dvs_d   = b;
               cnt_d   = '0;
               c_d     = c;
               d_d     = d;
               zero_d  = zero;
            end
         end
         DIV1, DIV2: begin
            rem_d = rem_step;
            quo_d = {quo_q[DATAWIDTH-2:0], ge};
            cnt_d = cnt_q + 1'b1;
            if (last) state_d = (state_q == DIV1) ? CHECK : DONE;
         end
         CHECK: begin
            eq_d  = (rem_q == zero_q);
            q1_d  = quo_q;
            rem_d = '0;
            quo_d = c_q;
            dvs_d = d_q;
            cnt_d = '0;
`ifdef CIRCUIT7_SKIP_EN
            state_d = eq_d ? DIV2 : DONE;
`else
            state_d = DIV2;
`endif
         end
         DONE: begin
            z_d     = eq_q ? quo_q : q1_q;
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         rem_q  <= '0;
         quo_q  <= '0;
         dvs_q  <= '0;
         cnt_q  <= '0;
         c_q    <= '0;
         d_q    <= '0;
         zero_q <= '0;
         q1_q   <= '0;
         eq_q   <= 1'b0;
         z_q    <= '0;
         done_q <= 1'b0;
      end else begin
         rem_q  <= rem_d;
         quo_q  <= quo_d;
         dvs_q  <= dvs_d;
         cnt_q  <= cnt_d;
         c_q    <= c_d;
         d_q    <= d_d;
         zero_q <= zero_d;
         q1_q   <= q1_d;
         eq_q   <= eq_d;
         z_q    <= z_d;
         done_q <= done_d;
      end
   end

   assign busy = (state_q != IDLE);
   assign done = done_q;
   assign z    = z_q;

endmodule

// File: tb/tb_circuit7_seq.sv
// Randomized self-checking bench for circuit7_seq at DATAWIDTH=8.
module tb_circuit7_seq;
   localparam int W = 8;

   logic         Clk = 1'b0;
   logic         Rst = 1'b0;
   logic         start = 1'b0;
   logic [W-1:0] a = '0, b = '0, c = '0, d = '0, zero = '0;
   logic         busy, done;
   logic [W-1:0] z;

   int nchk = 0;
   int nerr = 0;
   int done_cnt = 0;

   circuit7_seq #(.DATAWIDTH(W)) dut (
      .Clk(Clk), .Rst(Rst), .start(start),
      .a(a), .b(b), .c(c), .d(d), .zero(zero),
      .busy(busy), .done(done), .z(z)
   );

   always #5 Clk = ~Clk;

   always @(negedge Clk) if (done === 1'b1) done_cnt++;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nchk++;
      if (obs !== exp) begin
         nerr++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   // Reference: plain integer division with the divide-by-zero convention.
   function automatic void model(input logic [W-1:0] ia, ib, ic, id, iz,
                                 output logic [W-1:0] ez, output int elat);
      int q1, r1, q2;
      q1 = (ib == 0) ? 255 : int'(ia) / int'(ib);
      r1 = (ib == 0) ? int'(ia) : int'(ia) % int'(ib);
      q2 = (id == 0) ? 255 : int'(ic) / int'(id);
      ez = (r1 == int'(iz)) ? W'(q2) : W'(q1);
      elat = 2*W + 2;
`ifdef CIRCUIT7_SKIP_EN
      if (r1 != int'(iz)) elat = W + 2;
`endif
   endfunction

   task automatic issue(input logic [W-1:0] ia, ib, ic, id, iz);
      a = ia; b = ib; c = ic; d = id; zero = iz;
      start = 1'b1;
      tick();
      start = 1'b0;
      a = W'($urandom); b = W'($urandom); c = W'($urandom);
      d = W'($urandom); zero = W'($urandom);
   endtask

   task automatic wait_done(input int lat0, output int lat);
      lat = lat0;
      while (done !== 1'b1 && lat < 300) begin
         tick();
         lat++;
      end
   endtask

   task automatic run_check(input string tag, input logic [W-1:0] ia, ib, ic, id, iz);
      logic [W-1:0] ez;
      int elat, lat;
      model(ia, ib, ic, id, iz, ez, elat);
      issue(ia, ib, ic, id, iz);
      chk({tag, "_busy"}, busy, 1);
      wait_done(0, lat);
      chk({tag, "_lat"}, lat, elat);
      chk({tag, "_z"}, z, ez);
      tick();
      chk({tag, "_pulse"}, done, 0);
      chk({tag, "_idle"}, busy, 0);
   endtask

   initial begin
      logic [W-1:0] ez, ez2, ra, rb, rc, rd, rz;
      int elat, elat2, lat, gap, dc0;

      repeat (3) @(posedge Clk);
      #1;
      chk("rst_z", z, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      Rst = 1'b1;
      tick();

      run_check("t17_5", 8'd17, 8'd5, 8'd100, 8'd7, 8'd0);
      run_check("t15_5", 8'd15, 8'd5, 8'd100, 8'd7, 8'd0);
      run_check("tdiv0", 8'd9, 8'd0, 8'd50, 8'd0, 8'd9);

      // Reset four cycles into DIV1 aborts silently.
      issue(8'd200, 8'd3, 8'd10, 8'd2, 8'd1);
      repeat (3) tick();
      dc0 = done_cnt;
      Rst = 1'b0;
      #1;
      chk("abort_z", z, 0);
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      repeat (2) tick();
      Rst = 1'b1;
      repeat (25) tick();
      chk("abort_nodone", done_cnt - dc0, 0);
      run_check("post_rst", 8'd200, 8'd3, 8'd10, 8'd2, 8'd1);

      // Second start during DIV1 must be dropped.
      model(8'd77, 8'd10, 8'd90, 8'd9, 8'd7, ez, elat);
      dc0 = done_cnt;
      issue(8'd77, 8'd10, 8'd90, 8'd9, 8'd7);
      repeat (3) tick();
      a = 8'd8; b = 8'd2; c = 8'd1; d = 8'd1; zero = 8'd0;
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_done(4, lat);
      chk("ign_lat", lat, elat);
      chk("ign_z", z, ez);
      repeat (30) tick();
      chk("ign_count", done_cnt - dc0, 1);

      // start held high across two back-to-back computations.
      model(8'd40, 8'd6, 8'd81, 8'd9, 8'd4, ez, elat);
      model(8'd90, 8'd7, 8'd60, 8'd5, 8'd0, ez2, elat2);
      dc0 = done_cnt;
      a = 8'd40; b = 8'd6; c = 8'd81; d = 8'd9; zero = 8'd4;
      start = 1'b1;
      tick();
      wait_done(0, lat);
      chk("held1_lat", lat, elat);
      chk("held1_z", z, ez);
      a = 8'd90; b = 8'd7; c = 8'd60; d = 8'd5; zero = 8'd0;
      tick();
      wait_done(1, gap);
      start = 1'b0;
      chk("held2_gap", gap, elat2 + 1);
      chk("held2_z", z, ez2);
      repeat (30) tick();
      chk("held_count", done_cnt - dc0, 2);

      for (int i = 0; i < 24; i++) begin
         ra = W'($urandom);
         rb = ($urandom_range(0, 7) == 0) ? 8'd0 : W'($urandom_range(1, 20));
         rc = W'($urandom);
         rd = ($urandom_range(0, 5) == 0) ? 8'd0 : W'($urandom_range(1, 30));
         if ($urandom_range(0, 1) == 1) rz = (rb == 0) ? ra : ra % rb;
         else                           rz = W'($urandom_range(0, 12));
         run_check($sformatf("rnd%0d", i), ra, rb, rc, rd, rz);
      end

      $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
      $finish;
   end
endmodule

// File: doc/circuit7_seq.md
CIRCUIT7_SEQ -- requirements
Module: circuit7_seq

Interface
REQ-001 The block SHALL have parameter DATAWIDTH, default 64, giving the operand and result width in bits.
REQ-002 The block SHALL have port Clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port Rst, input, 1 bit: asynchronous, active-low reset (asserted when 0).
REQ-004 The block SHALL have port start, input, 1 bit: request to begin one computation; sampled only in IDLE.
REQ-005 The block SHALL have ports a, b, c, d, zero, input, DATAWIDTH each: operands, latched when start is accepted.
REQ-006 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-007 The block SHALL have port done, output, 1 bit: one-cycle pulse when z is updated.
REQ-008 The block SHALL have port z, output, DATAWIDTH: registered result; holds its value between computations.

Function
REQ-009 The block SHALL compute z = (a mod b == zero) ? c/d : a/b, unsigned, using one shared iterative restoring divider that yields 1 quotient bit per cycle.
REQ-010 The FSM SHALL have states IDLE, DIV1, CHECK, DIV2 and DONE.
REQ-011 IDLE SHALL go to DIV1 when start=1, latching all five operands and loading the divider with a and b.
REQ-012 DIV1 SHALL run exactly DATAWIDTH cycles, then go to CHECK holding quotient q1 and remainder r1.
REQ-013 CHECK SHALL take 1 cycle and register eq = (r1 == zero).
- If eq=1: go to DIV2 with the divider loaded with c and d.
- If eq=0: go per REQ-022.
REQ-014 DIV2 SHALL run exactly DATAWIDTH cycles, then go to DONE.
REQ-015 DONE SHALL take 1 cycle, load z (q2 if eq=1, else q1), assert done, and return to IDLE.
REQ-016 Latency from the start-accept edge to done high SHALL be 2*DATAWIDTH+2 cycles on the full path and DATAWIDTH+2 cycles on the skip path.
REQ-017 The divider SHALL handle divide-by-zero as follows: quotient all ones, remainder equal to the dividend.
REQ-018 Asserting start while busy=1 SHALL be ignored; no queuing of requests.
REQ-019 start held high continuously SHALL begin a new computation in the cycle after DONE, i.e. on the IDLE cycle following it.
REQ-020 Operand input changes after acceptance SHALL NOT affect the result in flight.

Reset
REQ-021 While Rst=0, the block SHALL immediately force:
- state to IDLE
- z to 0, busy to 0, done to 0
- divider registers, latched operands and eq to 0
- any computation in flight aborted, with no done pulse.

Configuration
REQ-022 Macro CIRCUIT7_SKIP_EN SHALL select the eq=0 path out of CHECK.
- Defined: CHECK goes directly to DONE (skip path, DATAWIDTH+2 latency).
- Undefined: CHECK always goes to DIV2, so c/d is computed unconditionally and latency is fixed at 2*DATAWIDTH+2; the z selection is unchanged.

Verification (DATAWIDTH=8)
REQ-023 The bench SHALL cover: a=17, b=5, zero=0, c=100, d=7, start pulse -> z=3, done after 10 cycles (SKIP_EN) or 18 cycles (not defined).
REQ-024 The bench SHALL cover: a=15, b=5, zero=0, c=100, d=7 -> z=14, done after 18 cycles in both builds.
REQ-025 The bench SHALL cover: a=9, b=0, zero=9, c=50, d=0 -> remainder 9 equals zero, so z=255 (c/0).
REQ-026 The bench SHALL cover: Rst driven low 4 cycles into DIV1 -> z=0, busy=0 immediately, no done pulse; a later start computes correctly.
REQ-027 The bench SHALL cover: start pulsed again mid-DIV1 with different operands -> ignored; z reflects the first operands only; exactly one done pulse.
REQ-028 The bench SHALL cover: start held high across two computations -> two done pulses separated by latency+1 cycles; z matches each.
